rx_ctrl: RTL and testbench

RX_CTRL -- requirements
Module: rx_ctrl

---
 rtl/rx_pkg.sv | 29 ++
 rtl/rx_ctrl_if.sv | 35 +++
 rtl/bit_tmr.sv | 43 ++++
 rtl/rx_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_rx_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared constants for the rx_ctrl serial receiver: state
//               encoding, default widths and the per-frame shift count.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

    // Default width of the bit-time count input
    localparam int c_k_w     = 19;
    // Default width of the external shift register
    localparam int c_frame_w = 10;
    // Smallest bit time the timer will accept
    localparam int c_k_min   = 4;

    // Receiver state encoding
    localparam int               c_st_w     = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_start = 2'd1;
    localparam logic [c_st_w-1:0] c_st_data  = 2'd2;

    // Shifts per frame: 7 or 8 data bits, optional parity, one stop bit
    function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
        return 4'd8 + {3'd0, eight} + {3'd0, pen};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_ctrl_if
// Description : Host and shift-register side signals of the rx_ctrl
//               receiver. The receiver owns the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_ctrl_if
    import rx_pkg::*;
#(
    parameter int FRAME_W = c_frame_w
) ();

    logic               sh;
    logic               sdi;
    logic [FRAME_W-1:0] shiftout;
    logic               rd;
    logic [7:0]         data;
    logic               rxrdy;
    logic               perr;
    logic               ferr;
    logic               ovf;

    modport master (
        output sh, sdi, data, rxrdy, perr, ferr, ovf,
        input  shiftout, rd
    );

    modport slave (
        input  sh, sdi, data, rxrdy, perr, ferr, ovf,
        output shiftout, rd
    );

endinterface
`default_nettype wire

// File: rtl/bit_tmr.sv
`default_nettype none
// ============================================================================
// Module      : bit_tmr
// Description : Loadable up-counter with a terminal-count pulse. The limit is
//               captured whenever the counter restarts (clear or terminal
//               count), so a single timer serves half-bit and full-bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_tmr
    import rx_pkg::*;
#(
    parameter int K_W = c_k_w
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic [K_W-1:0] limit,
    output logic           tc
);

    logic [K_W-1:0] r_cnt;
    logic [K_W-1:0] r_lim;
    logic           w_tc;

    // Terminal count fires on the last cycle of each period of r_lim cycles
    assign w_tc = ~clr & (r_cnt == (r_lim - K_W'(1)));
    assign tc   = w_tc;

    // Count up; restart from zero and resample the limit on clear or terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_lim <= '0;
        end else if (clr || w_tc) begin
            r_cnt <= '0;
            r_lim <= limit;
        end else begin
            r_cnt <= r_cnt + K_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_ctrl
// Description : Asynchronous serial receiver controller. Detects a start bit,
//               times bit centres, drives an external shift register and
//               decodes the completed frame into data and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_ctrl
    import rx_pkg::*;
#(
    parameter int K_W     = c_k_w,
    parameter int FRAME_W = c_frame_w
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    input  logic [K_W-1:0] k,
    input  logic           eight,
    input  logic           pen,
    input  logic           ohel,
    rx_ctrl_if.master      bus
);

    // Line synchronizer and start qualification
    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxs;
    logic [1:0]        r_settle;
    logic              r_armed;

    // Control state
    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next;
    logic              r_eight;
    logic              r_pen;
    logic              r_ohel;
    logic [3:0]        r_bitcnt;
    logic [3:0]        w_nbits;
    logic              w_last;

    // Timer
    logic [K_W-1:0]    w_kc;
    logic [K_W-1:0]    w_limit;
    logic              w_tmr_clr;
    logic              w_tc;

    // FSM outputs
    logic              w_start;
    logic              w_sh;
    logic              w_done;

    // Frame decode
    logic [3:0]        w_shamt;
    logic [7:0]        w_just;
    logic [7:0]        w_data_new;
    logic              w_stop;
    logic              w_par;
    logic              w_perr_new;

    // Output registers
    logic [7:0]        r_data;
    logic              r_rxrdy;
    logic              r_perr;
    logic              r_ferr;
    logic              r_ovf;

    assign w_rxs   = r_sync2;
    assign w_nbits = frame_bits(r_eight, r_pen);
    assign w_last  = (r_bitcnt == w_nbits);

    // Bit times shorter than the minimum are raised to it; IDLE loads a half bit
    assign w_kc    = (k < K_W'(c_k_min)) ? K_W'(c_k_min) : k;
    assign w_limit = (r_state == c_st_idle) ? (w_kc >> 1) : w_kc;

    bit_tmr #(
        .K_W   (K_W)
    ) u_tmr (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tmr_clr),
        .limit (w_limit),
        .tc    (w_tc)
    );

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Arm start detection only after the synchronizer has flushed its reset
    // value and a genuine idle-high line has been seen, so a line held low
    // across reset cannot start a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_settle <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[0], 1'b1};
            if (r_settle[1] && w_rxs) begin
                r_armed <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_armed && !w_rxs) begin
                    w_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_tc) begin
                    w_next = w_rxs ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (w_last) begin
                    w_next = c_st_idle;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    // FSM outputs: start detect, timer hold, shift pulse and frame completion
    always_comb begin
        w_start   = 1'b0;
        w_tmr_clr = 1'b0;
        w_sh      = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_tmr_clr = 1'b1;
                w_start   = r_armed & ~w_rxs;
            end
            c_st_data: begin
                w_sh   = w_tc & ~w_last;
                w_done = w_last;
            end
            default: begin
                w_tmr_clr = 1'b0;
            end
        endcase
    end

    // Frame format is frozen at start detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eight <= 1'b0;
            r_pen   <= 1'b0;
            r_ohel  <= 1'b0;
        end else if (w_start) begin
            r_eight <= eight;
            r_pen   <= pen;
            r_ohel  <= ohel;
        end
    end

    // Bit counter: zero outside DATA, one step per shift pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= 4'd0;
        end else if (r_state != c_st_data) begin
            r_bitcnt <= 4'd0;
        end else if (w_sh) begin
            r_bitcnt <= r_bitcnt + 4'd1;
        end
    end

    // The shift register fills from the MSB, so after nbits shifts the stop
    // bit sits at the top, parity (if any) just below, and the first data bit
    // lands at bit 0 once the frame is shifted down by FRAME_W - nbits.
    assign w_shamt    = 4'(FRAME_W) - w_nbits;
    assign w_just     = 8'(bus.shiftout >> w_shamt);
    assign w_data_new = r_eight ? w_just : {1'b0, w_just[6:0]};
    assign w_stop     = bus.shiftout[FRAME_W-1];
    assign w_par      = bus.shiftout[FRAME_W-2];
    assign w_perr_new = r_pen & ((^w_data_new) ^ w_par ^ r_ohel);

    // Status and data: completion beats a simultaneous read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= 8'd0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_done) begin
            r_data  <= w_data_new;
            r_perr  <= w_perr_new;
            r_ferr  <= ~w_stop;
            r_rxrdy <= 1'b1;
            r_ovf   <= r_ovf | (r_rxrdy & ~bus.rd);
        end else if (bus.rd) begin
            r_rxrdy <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign bus.sh    = w_sh;
    assign bus.sdi   = w_rxs;
    assign bus.data  = r_data;
    assign bus.rxrdy = r_rxrdy;
    assign bus.perr  = r_perr;
    assign bus.ferr  = r_ferr;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_ctrl
// Description : Directed self-checking bench for rx_ctrl with a model of the
//               external shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_ctrl;
    import rx_pkg::*;

    localparam int K_W     = 19;
    localparam int FRAME_W = 10;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic               rx    = 1'b1;
    logic [K_W-1:0]     k     = K_W'(8);
    logic               eight = 1'b1;
    logic               pen   = 1'b0;
    logic               ohel  = 1'b0;
    logic [FRAME_W-1:0] sr    = '1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int sh_total = 0;
    int sh_last  = 0;
    int gap_bad  = 0;
    int exp_gap  = 8;

    rx_ctrl_if #(.FRAME_W(FRAME_W)) bus ();

    rx_ctrl #(
        .K_W     (K_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .k     (k),
        .eight (eight),
        .pen   (pen),
        .ohel  (ohel),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External shift register: shifts sdi in at the MSB on each sh
    always @(posedge clk) begin
        if (bus.sh === 1'b1) begin
            sr <= {bus.sdi, sr[FRAME_W-1:1]};
        end
    end
    assign bus.shiftout = sr;

    // Count sh pulses and flag any in-frame spacing other than the bit time
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.sh === 1'b1) begin
            sh_total <= sh_total + 1;
            if (sh_total > 0 && (cyc - sh_last) < 2 * exp_gap && (cyc - sh_last) != exp_gap) begin
                gap_bad <= gap_bad + 1;
            end
            sh_last <= cyc;
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic e8, input logic par_en,
                              input logic par, input logic stop, input int bt);
        rx = 1'b0;
        clk_n(bt);
        for (int i = 0; i < (e8 ? 8 : 7); i++) begin
            rx = d[i];
            clk_n(bt);
        end
        if (par_en) begin
            rx = par;
            clk_n(bt);
        end
        rx = stop;
        clk_n(bt);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        bus.rd = 1'b1;
        clk_n(1);
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        int s0;
        reset = 1'b0;
        rx    = 1'b0;
        clk_n(3);
        n_checks++;
        if ({bus.sh, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.sh, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf});
        end
        n_checks++;
        if (dut.r_state !== c_st_idle) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.r_state, c_st_idle);
        end
        // Line held low across release must not start a frame
        s0    = sh_total;
        reset = 1'b1;
        clk_n(20);
        n_checks++;
        if (dut.r_state !== c_st_idle || sh_total != s0) begin
            n_errors++;
            $display("FAIL reset_no_start: state %0d sh %0d expected state 0 sh 0",
                     dut.r_state, sh_total - s0);
        end
        rx = 1'b1;
        clk_n(8);
    endtask

    task automatic test_basic_frame();
        int s0, g0;
        k = K_W'(8); eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        s0 = sh_total; g0 = gap_bad;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        clk_n(4);
        n_checks++;
        if (sh_total - s0 != 9) begin
            n_errors++;
            $display("FAIL basic_sh_count: got %0d expected 9", sh_total - s0);
        end
        n_checks++;
        if (gap_bad != g0) begin
            n_errors++;
            $display("FAIL basic_sh_gap: got %0d bad gaps expected 0", gap_bad - g0);
        end
        n_checks++;
        if (bus.data !== 8'h55) begin
            n_errors++;
            $display("FAIL basic_data: got %h expected 55", bus.data);
        end
        n_checks++;
        if ({bus.rxrdy, bus.perr, bus.ferr, bus.ovf} !== 4'b1000) begin
            n_errors++;
            $display("FAIL basic_flags: got %b expected 1000",
                     {bus.rxrdy, bus.perr, bus.ferr, bus.ovf});
        end
        pulse_rd();
        clk_n(1);
        n_checks++;
        if (bus.rxrdy !== 1'b0 || bus.data !== 8'h55) begin
            n_errors++;
            $display("FAIL basic_rd: rxrdy %b data %h expected 0 55", bus.rxrdy, bus.data);
        end
    endtask

    task automatic test_false_start();
        int s0;
        s0 = sh_total;
        rx = 1'b0;
        clk_n(2);
        rx = 1'b1;
        clk_n(3);
        n_checks++;
        if (dut.r_state !== c_st_start) begin
            n_errors++;
            $display("FAIL false_start_enter: got %0d expected %0d", dut.r_state, c_st_start);
        end
        clk_n(12);
        n_checks++;
        if (dut.r_state !== c_st_idle) begin
            n_errors++;
            $display("FAIL false_start_idle: got %0d expected %0d", dut.r_state, c_st_idle);
        end
        n_checks++;
        if (sh_total != s0 || bus.rxrdy !== 1'b0) begin
            n_errors++;
            $display("FAIL false_start_quiet: sh %0d rxrdy %b expected 0 0",
                     sh_total - s0, bus.rxrdy);
        end
    endtask

    task automatic test_parity();
        int s0;
        eight = 1'b1; pen = 1'b1; ohel = 1'b0;
        s0 = sh_total;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8);
        clk_n(4);
        n_checks++;
        if (bus.data !== 8'hA3 || bus.perr !== 1'b1) begin
            n_errors++;
            $display("FAIL parity_bad: data %h perr %b expected a3 1", bus.data, bus.perr);
        end
        n_checks++;
        if (sh_total - s0 != 10) begin
            n_errors++;
            $display("FAIL parity_sh_count: got %0d expected 10", sh_total - s0);
        end
        pulse_rd();
        clk_n(8);
        // Format changes mid-frame must not affect this frame
        s0 = sh_total;
        fork
            send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 8);
            begin
                clk_n(30);
                ohel = 1'b1; eight = 1'b0; pen = 1'b0;
            end
        join
        clk_n(4);
        n_checks++;
        if (bus.data !== 8'hA3 || bus.perr !== 1'b0 || bus.ferr !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_good: data %h perr %b ferr %b expected a3 0 0",
                     bus.data, bus.perr, bus.ferr);
        end
        n_checks++;
        if (sh_total - s0 != 10) begin
            n_errors++;
            $display("FAIL parity_latch_sh_count: got %0d expected 10", sh_total - s0);
        end
        pulse_rd();
        ohel = 1'b0;
    endtask

    task automatic test_framing_7bit();
        int s0;
        eight = 1'b0; pen = 1'b0;
        clk_n(8);
        s0 = sh_total;
        send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        clk_n(4);
        n_checks++;
        if (bus.data !== 8'h41 || bus.ferr !== 1'b1 || bus.perr !== 1'b0) begin
            n_errors++;
            $display("FAIL framing_7bit: data %h ferr %b perr %b expected 41 1 0",
                     bus.data, bus.ferr, bus.perr);
        end
        n_checks++;
        if (sh_total - s0 != 8) begin
            n_errors++;
            $display("FAIL framing_sh_count: got %0d expected 8", sh_total - s0);
        end
        clk_n(16);
        pulse_rd();
        clk_n(2);
    endtask

    task automatic test_overrun();
        eight = 1'b1; pen = 1'b0;
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        clk_n(4);
        n_checks++;
        if (bus.rxrdy !== 1'b1 || bus.ovf !== 1'b0 || bus.data !== 8'h12) begin
            n_errors++;
            $display("FAIL overrun_first: rxrdy %b ovf %b data %h expected 1 0 12",
                     bus.rxrdy, bus.ovf, bus.data);
        end
        send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        clk_n(4);
        n_checks++;
        if (bus.rxrdy !== 1'b1 || bus.ovf !== 1'b1 || bus.data !== 8'h34) begin
            n_errors++;
            $display("FAIL overrun_second: rxrdy %b ovf %b data %h expected 1 1 34",
                     bus.rxrdy, bus.ovf, bus.data);
        end
        pulse_rd();
        clk_n(1);
        n_checks++;
        if (bus.rxrdy !== 1'b0 || bus.ovf !== 1'b0 || bus.data !== 8'h34 || bus.ferr !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_rd: rxrdy %b ovf %b data %h ferr %b expected 0 0 34 0",
                     bus.rxrdy, bus.ovf, bus.data, bus.ferr);
        end
    endtask

    task automatic test_k_clamp();
        int s0, g0;
        k = K_W'(2);
        exp_gap = 4;
        clk_n(8);
        s0 = sh_total; g0 = gap_bad;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        clk_n(4);
        n_checks++;
        if (bus.data !== 8'h96 || sh_total - s0 != 9) begin
            n_errors++;
            $display("FAIL k_clamp_frame: data %h sh %0d expected 96 9", bus.data, sh_total - s0);
        end
        n_checks++;
        if (gap_bad != g0) begin
            n_errors++;
            $display("FAIL k_clamp_gap: got %0d bad gaps expected 0", gap_bad - g0);
        end
        k = K_W'(8);
        clk_n(8);
        exp_gap = 8;
    endtask

    task automatic test_reset_midframe();
        int s0;
        logic [7:0] d;
        d = 8'h5A;
        eight = 1'b1; pen = 1'b0;
        s0 = sh_total;
        rx = 1'b0;
        clk_n(8);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            clk_n(8);
        end
        rx = d[3];
        clk_n(4);
        n_checks++;
        if (sh_total - s0 != 3) begin
            n_errors++;
            $display("FAIL midframe_progress: got %0d sh expected 3", sh_total - s0);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.sh, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf} !== 13'd0) begin
            n_errors++;
            $display("FAIL midframe_reset_outputs: got %h expected 0",
                     {bus.sh, bus.data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf});
        end
        n_checks++;
        if (dut.r_state !== c_st_idle) begin
            n_errors++;
            $display("FAIL midframe_reset_state: got %0d expected %0d", dut.r_state, c_st_idle);
        end
        rx = 1'b1;
        clk_n(3);
        reset = 1'b1;
        clk_n(8);
        eight = 1'b1; pen = 1'b1; ohel = 1'b1;
        s0 = sh_total;
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8);
        clk_n(4);
        n_checks++;
        if (bus.data !== 8'hC3 || {bus.rxrdy, bus.perr, bus.ferr, bus.ovf} !== 4'b1000) begin
            n_errors++;
            $display("FAIL midframe_next_frame: data %h flags %b expected c3 1000",
                     bus.data, {bus.rxrdy, bus.perr, bus.ferr, bus.ovf});
        end
        n_checks++;
        if (sh_total - s0 != 10) begin
            n_errors++;
            $display("FAIL midframe_sh_count: got %0d expected 10", sh_total - s0);
        end
    endtask

    initial begin
        bus.rd = 1'b0;
        test_reset();
        test_basic_frame();
        test_false_start();
        test_parity();
        test_framing_7bit();
        test_overrun();
        test_k_clamp();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
